fetch_stage: RTL and testbench

- IF stage of the 5-stage RISC-V pipeline, directly upstream of the instruction memory.
- Owns the fetch PC and drives the byte address into the combinational IMem, which is indexed by PC with a step of 4.
- Captures the returned word into the IF/ID pipeline register.
- Handles branch/jump redirects, hazard stalls and flushes, external interrupt entry to a fixed vector, and mret return via a saved mepc.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RISC-V pipeline.
//
// Owns the fetch PC, drives it straight into the combinational instruction
// memory and captures the returned word into the IF/ID register. The next PC
// comes from one of several sources: a branch/jump redirect from EX, an mret
// return to the saved mepc, entry to the interrupt vector, a hazard stall, or
// sequential fetch.
//
// Ports:
//   clk, rst         clock (rising edge) and synchronous active-high reset
//   stall_f          hold the fetch PC
//   stall_d          hold the IF/ID register
//   flush_d          replace the IF/ID contents with a bubble
//   branch_taken_e   redirect request from EX, with target branch_target_e
//   mret_d           decode holds an mret in IF/ID
//   irq              level-sensitive external interrupt
//   imem_addr        byte address into IMem (always equal to pc_f)
//   imem_instr       IMem read data for imem_addr, same cycle
//   pc_f             current fetch PC
//   instr_d, pc_d, pc_plus4_d, valid_d   IF/ID register contents
//   mepc             PC to return to on mret
//   in_isr           interrupt handler active; masks irq
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(300),
  parameter int unsigned           PC_STEP     = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INSTR   = INST_WIDTH'(32'h00000013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  branch_taken_e,
  input  logic [ADDR_WIDTH-1:0] branch_target_e,
  input  logic                  mret_d,
  input  logic                  irq,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_instr,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [INST_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic [ADDR_WIDTH-1:0] mepc,
  output logic                  in_isr
);

  logic                  mret_eff;
  logic                  irq_acc;
  logic                  bubble_d;
  logic [ADDR_WIDTH-1:0] pc_seq;

  assign imem_addr = pc_f;
  assign pc_seq    = pc_f + ADDR_WIDTH'(PC_STEP);

  // An mret only counts when the decode slot holds a real instruction; a
  // squashed mret must not return.
  assign mret_eff = mret_d & valid_d;

  // Interrupts are accepted only when nothing older is redirecting the PC and
  // the PC is free to move. A refused irq is simply seen again next cycle
  // because it is level-sensitive.
  assign irq_acc = irq & ~in_isr & ~stall_f & ~branch_taken_e & ~mret_eff;

  // Every PC redirect squashes the word fetched this cycle.
  assign bubble_d = branch_taken_e | mret_eff | irq_acc | flush_d;

  // Fetch PC, saved return PC and handler flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f   <= RESET_PC;
      mepc   <= '0;
      in_isr <= 1'b0;
    end else if (branch_taken_e) begin
      pc_f <= branch_target_e;
    end else if (mret_eff) begin
      pc_f   <= mepc;
      in_isr <= 1'b0;
    end else if (irq_acc) begin
      // The instruction at pc_f is squashed, so it is the one to re-execute.
      pc_f   <= TRAP_VECTOR;
      mepc   <= pc_f;
      in_isr <= 1'b1;
    end else if (!stall_f) begin
      pc_f <= pc_seq;
    end
  end

  // IF/ID pipeline register; a bubble wins over a decode stall.
  always_ff @(posedge clk) begin
    if (rst || bubble_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= imem_instr;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_seq;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
//
// Each step drives the inputs for one cycle and pushes the state expected
// after the following rising edge into a scoreboard queue; the entry is
// popped and compared against the DUT on the falling edge after that edge.
// IMem is modelled by imem_word(), with the mret encoding at 316 and a
// distinct addi word everywhere else.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] MRET = 32'h30200073;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic        mret_d;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] mepc;
  logic        in_isr;

  typedef struct {
    string       tag;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic        valid_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        in_isr;
    logic [31:0] mepc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .mret_d          (mret_d),
    .irq             (irq),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .mepc            (mepc),
    .in_isr          (in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] idx;
    if (a == 32'd40)  return 32'h00a00613;
    if (a == 32'd316) return MRET;
    idx = (a >> 2) + 32'd1;
    return (idx << 20) | 32'h00000093;
  endfunction

  always_comb imem_instr = imem_word(imem_addr);

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
  endtask

  task automatic applyStimulus(
    input string tag,
    input logic r, input logic sf, input logic sd, input logic fl,
    input logic br, input logic [31:0] tgt, input logic mr, input logic iq,
    input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_v,
    input logic [31:0] e_pcd, input logic e_isr, input logic [31:0] e_mepc);
    exp_t e;
    rst             = r;
    stall_f         = sf;
    stall_d         = sd;
    flush_d         = fl;
    branch_taken_e  = br;
    branch_target_e = tgt;
    mret_d          = mr;
    irq             = iq;
    e.tag        = tag;
    e.pc_f       = e_pc;
    e.instr_d    = e_instr;
    e.valid_d    = e_v;
    e.pc_d       = e_pcd;
    e.pc_plus4_d = e_v ? e_pcd + 32'd4 : 32'd0;
    e.in_isr     = e_isr;
    e.mepc       = e_mepc;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "pc_f",       pc_f,               e.pc_f);
      cmp(e.tag, "imem_addr",  imem_addr,          e.pc_f);
      cmp(e.tag, "instr_d",    instr_d,            e.instr_d);
      cmp(e.tag, "valid_d",    {31'd0, valid_d},   {31'd0, e.valid_d});
      cmp(e.tag, "pc_d",       pc_d,               e.pc_d);
      cmp(e.tag, "pc_plus4_d", pc_plus4_d,         e.pc_plus4_d);
      cmp(e.tag, "in_isr",     {31'd0, in_isr},    {31'd0, e.in_isr});
      cmp(e.tag, "mepc",       mepc,               e.mepc);
    end
  endtask

  task automatic step(
    input string tag,
    input logic r, input logic sf, input logic sd, input logic fl,
    input logic br, input logic [31:0] tgt, input logic mr, input logic iq,
    input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_v,
    input logic [31:0] e_pcd, input logic e_isr, input logic [31:0] e_mepc);
    applyStimulus(tag, r, sf, sd, fl, br, tgt, mr, iq,
                  e_pc, e_instr, e_v, e_pcd, e_isr, e_mepc);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    branch_taken_e = 1'b0; branch_target_e = '0; mret_d = 1'b0; irq = 1'b0;
    @(negedge clk);

    //    tag            rst sf sd fl br  target         mr iq   pc_f           instr_d              v  pc_d           isr mepc
    step("reset",        1, 0, 0, 0, 0, 32'd0,          0, 0,  32'd0,         NOP,                 0, 32'd0,         0, 32'd0);
    step("run0",         0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd4,         32'h00100093,        1, 32'd0,         0, 32'd0);
    step("run1",         0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd8,         imem_word(32'd4),    1, 32'd4,         0, 32'd0);
    step("stall0",       0, 1, 1, 0, 0, 32'd0,          0, 0,  32'd8,         imem_word(32'd4),    1, 32'd4,         0, 32'd0);
    step("stall1",       0, 1, 1, 0, 0, 32'd0,          0, 0,  32'd8,         imem_word(32'd4),    1, 32'd4,         0, 32'd0);
    step("release",      0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd12,        imem_word(32'd8),    1, 32'd8,         0, 32'd0);
    step("run2",         0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd16,        imem_word(32'd12),   1, 32'd12,        0, 32'd0);
    step("br40_stall",   0, 1, 0, 0, 1, 32'd40,         0, 0,  32'd40,        NOP,                 0, 32'd0,         0, 32'd0);
    step("after_br40",   0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd44,        32'h00a00613,        1, 32'd40,        0, 32'd0);
    step("br20",         0, 0, 0, 0, 1, 32'd20,         0, 0,  32'd20,        NOP,                 0, 32'd0,         0, 32'd0);
    step("irq_take",     0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd300,       NOP,                 0, 32'd0,         1, 32'd20);
    step("isr300",       0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd304,       imem_word(32'd300),  1, 32'd300,       1, 32'd20);
    step("isr304",       0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd308,       imem_word(32'd304),  1, 32'd304,       1, 32'd20);
    step("isr308",       0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd312,       imem_word(32'd308),  1, 32'd308,       1, 32'd20);
    step("isr312",       0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd316,       imem_word(32'd312),  1, 32'd312,       1, 32'd20);
    step("isr316",       0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd320,       MRET,                1, 32'd316,       1, 32'd20);
    step("mret",         0, 0, 0, 0, 0, 32'd0,          1, 1,  32'd20,        NOP,                 0, 32'd0,         0, 32'd20);
    step("reirq",        0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd300,       NOP,                 0, 32'd0,         1, 32'd20);
    step("isr_again",    0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd304,       imem_word(32'd300),  1, 32'd300,       1, 32'd20);
    step("br_vs_mret",   0, 0, 0, 0, 1, 32'd8,          1, 0,  32'd8,         NOP,                 0, 32'd0,         1, 32'd20);
    step("isr_at8",      0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd12,        imem_word(32'd8),    1, 32'd8,         1, 32'd20);
    step("mret2",        0, 0, 0, 0, 0, 32'd0,          1, 0,  32'd20,        NOP,                 0, 32'd0,         0, 32'd20);
    step("irq_vs_br",    0, 0, 0, 0, 1, 32'd100,        0, 1,  32'd100,       NOP,                 0, 32'd0,         0, 32'd20);
    step("irq_after_br", 0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd300,       NOP,                 0, 32'd0,         1, 32'd100);
    step("isr_run",      0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd304,       imem_word(32'd300),  1, 32'd300,       1, 32'd100);
    step("rst_mid_isr",  1, 0, 0, 0, 0, 32'd0,          0, 0,  32'd0,         NOP,                 0, 32'd0,         0, 32'd0);
    step("mret_invalid", 0, 0, 0, 0, 0, 32'd0,          1, 0,  32'd4,         32'h00100093,        1, 32'd0,         0, 32'd0);
    step("mret_outside", 0, 0, 0, 0, 0, 32'd0,          1, 0,  32'd0,         NOP,                 0, 32'd0,         0, 32'd0);
    step("flush_stall",  0, 0, 1, 1, 0, 32'd0,          0, 0,  32'd4,         NOP,                 0, 32'd0,         0, 32'd0);
    step("irq_stalled",  0, 1, 0, 0, 0, 32'd0,          0, 1,  32'd4,         imem_word(32'd4),    1, 32'd4,         0, 32'd0);
    step("irq_retry",    0, 0, 0, 0, 0, 32'd0,          0, 1,  32'd300,       NOP,                 0, 32'd0,         1, 32'd4);
    step("wrap_br",      0, 0, 0, 0, 1, 32'hFFFFFFFC,   0, 0,  32'hFFFFFFFC,  NOP,                 0, 32'd0,         1, 32'd4);
    step("wrap_run",     0, 0, 0, 0, 0, 32'd0,          0, 0,  32'd0,  imem_word(32'hFFFFFFFC),    1, 32'hFFFFFFFC,  1, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
